// File: rtl/pong_pkg.sv
// Shared pong definitions: coordinate types, default screen bounds and the
// trajectory FSM state encoding.
package pong_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_X_MIN = 0;
  localparam int DEF_X_MAX = 629;
  localparam int DEF_Y_MIN = 10;
  localparam int DEF_Y_MAX = 469;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [COORD_W:0]   wide_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One guard bit wider than a coordinate so that a step past a bound cannot wrap.
  function automatic wide_t clamp_wide(input wide_t v, input wide_t lo, input wide_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/ball_path_stepper_if.sv
// Segment request / position bus between the collision controller (master)
// and the trajectory stepper (slave).
interface ball_path_stepper_if;
  import pong_pkg::*;

  logic   start;
  logic   abort;
  logic   x_dir;
  logic signed [3:0] slope;
  coord_t x0;
  coord_t y0;
  coord_t x;
  coord_t y;
  logic   busy;
  logic   done;

  modport master (
    output start, abort, x_dir, slope, x0, y0,
    input  x, y, busy, done
  );

  modport slave (
    input  start, abort, x_dir, slope, x0, y0,
    output x, y, busy, done
  );

endinterface

// File: rtl/step_timer.sv
// Free-running divider that strobes tick for one cycle every STEP_DIV enabled
// cycles; clear parks the count at zero.
module step_timer #(
  parameter int STEP_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/ball_path_stepper.sv
// Walks the ball one step per game tick along a straight segment until it
// lands on a screen bound (done pulse) or the controller aborts it.
module ball_path_stepper
  import pong_pkg::*;
#(
  parameter int STEP_DIV = 833333,
  parameter int X_MIN    = DEF_X_MIN,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int X_RESET  = 100,
  parameter int Y_RESET  = 100
) (
  input logic clk,
  input logic reset,
  ball_path_stepper_if.slave bus
);

  localparam wide_t XLO = wide_t'(X_MIN);
  localparam wide_t XHI = wide_t'(X_MAX);
  localparam wide_t YLO = wide_t'(Y_MIN);
  localparam wide_t YHI = wide_t'(Y_MAX);

  state_t state;
  state_t next_state;

  coord_t x_q;
  coord_t y_q;
  logic   dir_q;
  logic signed [3:0] slope_q;

  logic  tick;
  wide_t nx, ny, cx, cy;
  wide_t load_x, load_y;
  logic  hit_end;

  step_timer #(
    .STEP_DIV(STEP_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state != RUN),
    .en   (state == RUN),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = RUN;
      RUN: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (tick && hit_end) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN) || (state == DONE);
    bus.done = (state == DONE);
  end

  // A segment ends when a step is clipped or lands exactly on the bound it is
  // heading for; zero slope never ends on y.
  always_comb begin
    nx      = wide_t'(x_q) + (dir_q ? wide_t'(1) : wide_t'(-1));
    ny      = wide_t'(y_q) + wide_t'(slope_q);
    cx      = clamp_wide(nx, XLO, XHI);
    cy      = clamp_wide(ny, YLO, YHI);
    hit_end = (cx != nx) || (cy != ny) ||
              (dir_q ? (cx == XHI) : (cx == XLO)) ||
              ((slope_q > 4'sd0) && (cy == YHI)) ||
              ((slope_q < 4'sd0) && (cy == YLO));
    load_x  = clamp_wide(wide_t'(bus.x0), XLO, XHI);
    load_y  = clamp_wide(wide_t'(bus.y0), YLO, YHI);
  end

  // Abort outranks a coincident step, so the position only moves when the
  // strobe fires without an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= coord_t'(X_RESET);
      y_q     <= coord_t'(Y_RESET);
      dir_q   <= 1'b0;
      slope_q <= 4'sd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dir_q   <= bus.x_dir;
            slope_q <= bus.slope;
            x_q     <= coord_t'(load_x);
            y_q     <= coord_t'(load_y);
          end
        end
        RUN: begin
          if (!bus.abort && tick) begin
            x_q <= coord_t'(cx);
            y_q <= coord_t'(cy);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.x = x_q;
  assign bus.y = y_q;

endmodule

// File: tb/tb_ball_path_stepper.sv
// Randomized and directed bench for ball_path_stepper, checked every cycle
// against a step-list model of the ball trajectory.
module tb_ball_path_stepper;

  localparam int STEP_DIV = 4;
  localparam int XLO = 0;
  localparam int XHI = 629;
  localparam int YLO = 10;
  localparam int YHI = 469;

  typedef struct {
    int x;
    int y;
  } pt_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  pt_t  path[$];

  always #5 clk = ~clk;

  ball_path_stepper_if bus ();

  ball_path_stepper #(
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tickClk();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampInt(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // The whole segment as a list of positions: load point, then one entry per step.
  task automatic buildPath(input int x0, input int y0, input bit dir, input int slope);
    pt_t p;
    int  nx, ny;
    path.delete();
    p.x = clampInt(x0, XLO, XHI);
    p.y = clampInt(y0, YLO, YHI);
    path.push_back(p);
    for (int s = 0; s < 2000; s++) begin
      nx = p.x + (dir ? 1 : -1);
      ny = p.y + slope;
      p.x = clampInt(nx, XLO, XHI);
      p.y = clampInt(ny, YLO, YHI);
      path.push_back(p);
      if (p.x != nx || p.y != ny) break;
      if (p.x == (dir ? XHI : XLO)) break;
      if (slope > 0 && p.y == YHI) break;
      if (slope < 0 && p.y == YLO) break;
    end
  endtask

  task automatic expectState(input string tag, input int px, input int py, input bit busy, input bit done);
    logic [10:0] ex, ey;
    ex = px[10:0];
    ey = py[10:0];
    checkOutput({tag, "_pos"}, {10'd0, bus.x, bus.y}, {10'd0, ex, ey});
    checkOutput({tag, "_stat"}, {30'd0, bus.busy, bus.done}, {30'd0, busy, done});
  endtask

  task automatic scrambleInputs();
    bus.x_dir = 1'($urandom);
    bus.slope = 4'($urandom);
    bus.x0    = 11'($urandom);
    bus.y0    = 11'($urandom);
  endtask

  // Presents a segment request for one load edge, then scrambles the data
  // inputs, which must no longer matter.
  task automatic applyStimulus(input int x0, input int y0, input bit dir, input int slope);
    bus.x0    = 11'(x0);
    bus.y0    = 11'(y0);
    bus.x_dir = dir;
    bus.slope = 4'(slope);
    bus.start = 1'b1;
    buildPath(x0, y0, dir, slope);
    tickClk();
    bus.start = 1'b0;
    scrambleInputs();
  endtask

  task automatic runFromLoad(input string tag, input int maxSteps);
    int last;
    last = path.size() - 1;
    expectState({tag, "_load"}, path[0].x, path[0].y, 1'b1, 1'b0);
    for (int k = 1; k <= last && k <= maxSteps; k++) begin
      for (int c = 1; c < STEP_DIV; c++) begin
        tickClk();
        expectState({tag, "_wait"}, path[k-1].x, path[k-1].y, 1'b1, 1'b0);
      end
      tickClk();
      expectState({tag, "_step"}, path[k].x, path[k].y, 1'b1, k == last);
    end
    if (last <= maxSteps) begin
      tickClk();
      expectState({tag, "_idle"}, path[last].x, path[last].y, 1'b0, 1'b0);
    end
  endtask

  task automatic abortNow(input string tag, input int px, input int py);
    bus.abort = 1'b1;
    tickClk();
    bus.abort = 1'b0;
    expectState({tag, "_abort"}, px, py, 1'b0, 1'b0);
    tickClk();
    expectState({tag, "_abort_hold"}, px, py, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x_dir = 1'b0;
    bus.slope = 4'sd0;
    bus.x0    = '0;
    bus.y0    = '0;
    reset     = 1'b1;
    tickClk();
    tickClk();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      scrambleInputs();
      tickClk();
      expectState("reset_idle", 100, 100, 1'b0, 1'b0);
    end

    applyStimulus(100, 100, 1'b1, 2);
    runFromLoad("diag_pos", 5);
    expectState("diag_pos_s5", 105, 110, 1'b1, 1'b0);
    abortNow("diag_pos", 105, 110);

    applyStimulus(627, 200, 1'b1, -1);
    runFromLoad("right_edge", 100);
    expectState("right_edge_end", 629, 198, 1'b0, 1'b0);

    applyStimulus(300, 466, 1'b1, 7);
    runFromLoad("bottom_clip", 100);
    expectState("bottom_clip_end", 301, 469, 1'b0, 1'b0);

    applyStimulus(629, 300, 1'b1, 0);
    runFromLoad("on_bound", 100);

    applyStimulus(-5, 700, 1'b0, 0);
    runFromLoad("load_clamp", 100);

    // Abort on the same edge as the step strobe, with start already held high.
    applyStimulus(200, 200, 1'b0, -3);
    for (int c = 1; c < STEP_DIV; c++) begin
      tickClk();
      expectState("coinc_wait", 200, 200, 1'b1, 1'b0);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.x0    = 11'(50);
    bus.y0    = 11'(60);
    bus.x_dir = 1'b1;
    bus.slope = 4'sd1;
    buildPath(50, 60, 1'b1, 1);
    tickClk();
    bus.abort = 1'b0;
    expectState("coinc_abort", 200, 200, 1'b0, 1'b0);
    tickClk();
    bus.start = 1'b0;
    scrambleInputs();
    runFromLoad("coinc_reload", 3);
    abortNow("coinc_reload", 53, 63);

    applyStimulus(400, 300, 1'b0, 1);
    for (int c = 0; c < 6; c++) tickClk();
    reset = 1'b1;
    tickClk();
    reset = 1'b0;
    expectState("mid_reset", 100, 100, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tickClk();
      expectState("mid_reset_hold", 100, 100, 1'b0, 1'b0);
    end

    for (int n = 0; n < 12; n++) begin
      int rx, ry, rs;
      bit rd;
      rx = int'($urandom_range(0, 670)) - 20;
      ry = int'($urandom_range(0, 490)) - 10;
      rs = int'($urandom_range(0, 15)) - 8;
      rd = 1'($urandom);
      applyStimulus(rx, ry, rd, rs);
      runFromLoad("random", 5000);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        tickClk();
        expectState("random_gap", path[path.size()-1].x, path[path.size()-1].y, 1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
